// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS load/store unit: access sizes, FSM states and lane-offset width.
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      MemByte = 2'b00,
      MemHalf = 2'b01,
      MemWord = 2'b10,
      MemRsvd = 2'b11
   } mem_size_t;

   typedef enum logic {
      StIdle,
      StBus
   } mem_state_t;

   function automatic int unsigned lane_off_w(int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/mips_cpu_mem_unit_if.sv
// CPU request/response channel plus Avalon-MM master signals of the load/store unit.
interface mips_cpu_mem_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [ADDR_W-1:0]     req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic                  resp_err;
   logic [31:0]           resp_rdata;
   logic [ADDR_W-1:0]     address;
   logic                  read;
   logic                  write;
   logic                  waitrequest;
   logic [DATA_W-1:0]     writedata;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     readdata;

   // The unit itself is the Avalon master.
   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  waitrequest, readdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output address, read, write, writedata, byteenable
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output waitrequest, readdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  address, read, write, writedata, byteenable
   );

endinterface

// File: rtl/mips_cpu_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data
// and the misalignment flag for one access.
module mips_cpu_lane_align
   import mips_cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   localparam int unsigned OFF_W = lane_off_w(DATA_W),
   localparam int unsigned NB    = DATA_W / 8
) (
   input  logic [OFF_W-1:0]  i_off,
   input  mem_size_t         i_size,
   input  logic              i_signed,
   input  logic [31:0]       i_wdata,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [NB-1:0]     o_byteenable,
   output logic [DATA_W-1:0] o_writedata,
   output logic [31:0]       o_rdata,
   output logic              o_misalign
);

   logic [DATA_W-1:0] w_shifted;

   always_comb begin
      o_byteenable = '0;
      o_writedata  = '0;
      o_rdata      = '0;
      o_misalign   = 1'b0;
      w_shifted    = i_rdata >> {i_off, 3'b000};
      unique case (i_size)
         MemByte: begin
            o_byteenable = {{(NB-1){1'b0}}, 1'b1} << i_off;
            for (int k = 0; k < NB; k++) o_writedata[8*k +: 8] = i_wdata[7:0];
            o_rdata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
         end
         MemHalf: begin
            o_misalign   = i_off[0];
            o_byteenable = {{(NB-2){1'b0}}, 2'b11} << i_off;
            for (int k = 0; k < NB / 2; k++) o_writedata[16*k +: 16] = i_wdata[15:0];
            o_rdata = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
         end
         MemWord: begin
            o_misalign   = |i_off[1:0];
            o_byteenable = {{(NB-4){1'b0}}, 4'hF} << i_off;
            for (int k = 0; k < NB / 4; k++) o_writedata[32*k +: 32] = i_wdata;
            o_rdata = w_shifted[31:0];
         end
         default: o_misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_cpu_mem_unit.sv
// Load/store unit: turns one CPU byte/half/word request into one Avalon-MM transfer.
// Misaligned or reserved-size requests complete as errors without bus traffic.
module mips_cpu_mem_unit
   import mips_cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input logic                 clk,
   input logic                 reset,
   mips_cpu_mem_unit_if.master io_mem
);

   localparam int unsigned OFF_W = lane_off_w(DATA_W);
   localparam int unsigned NB    = DATA_W / 8;

   mem_state_t          r_state, w_state_d;
   logic [OFF_W-1:0]    r_off;
   mem_size_t           r_size;
   logic                r_signed;
   logic [ADDR_W-1:0]   r_address;
   logic                r_read, r_write;
   logic [DATA_W-1:0]   r_writedata;
   logic [NB-1:0]       r_byteenable;
   logic                r_resp_valid, r_resp_err;
   logic [31:0]         r_resp_rdata;

   logic                w_idle, w_accept, w_done, w_misalign, w_signed;
   logic [OFF_W-1:0]    w_off;
   mem_size_t           w_size;
   logic [NB-1:0]       w_byteenable;
   logic [DATA_W-1:0]   w_writedata;
   logic [31:0]         w_rdata;

   assign w_idle   = (r_state == StIdle);
   assign w_accept = w_idle & io_mem.req_valid;
   assign w_done   = (r_state == StBus) & ~io_mem.waitrequest;

   // Lane logic sees the live request while idle and the latched fields during the transfer.
   assign w_off    = w_idle ? io_mem.req_addr[OFF_W-1:0] : r_off;
   assign w_size   = w_idle ? mem_size_t'(io_mem.req_size) : r_size;
   assign w_signed = w_idle ? io_mem.req_signed : r_signed;

   mips_cpu_lane_align #(
      .DATA_W (DATA_W)
   ) u_lane_align (
      .i_off        (w_off),
      .i_size       (w_size),
      .i_signed     (w_signed),
      .i_wdata      (io_mem.req_wdata),
      .i_rdata      (io_mem.readdata),
      .o_byteenable (w_byteenable),
      .o_writedata  (w_writedata),
      .o_rdata      (w_rdata),
      .o_misalign   (w_misalign)
   );

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_accept && !w_misalign) w_state_d = StBus;
         StBus:   if (!io_mem.waitrequest) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_off        <= '0;
         r_size       <= MemByte;
         r_signed     <= 1'b0;
         r_address    <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_writedata  <= '0;
         r_byteenable <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_state      <= w_state_d;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         if (w_accept && w_misalign) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
         end else if (w_accept) begin
            r_off        <= w_off;
            r_size       <= w_size;
            r_signed     <= w_signed;
            r_address    <= {io_mem.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_writedata  <= w_writedata;
            r_byteenable <= w_byteenable;
            r_read       <= ~io_mem.req_write;
            r_write      <= io_mem.req_write;
         end
         if (w_done) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_valid <= 1'b1;
            if (r_read) r_resp_rdata <= w_rdata;
         end
      end
   end

   assign io_mem.req_ready  = w_idle & reset;
   assign io_mem.resp_valid = r_resp_valid;
   assign io_mem.resp_err   = r_resp_err;
   assign io_mem.resp_rdata = r_resp_rdata;
   assign io_mem.address    = r_address;
   assign io_mem.read       = r_read;
   assign io_mem.write      = r_write;
   assign io_mem.writedata  = r_writedata;
   assign io_mem.byteenable = r_byteenable;

endmodule
